// File: rtl/dmem_lsu_pkg.sv
// Shared size encodings and FSM state type for the DMEM load/store unit.
package dmem_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    ERR_CHK,
    ISSUE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/dmem_lsu_load_extend.sv
// Combinational sign/zero extension of right-justified DMEM read data.
// Zero latency; no flow control.
module lsu_load_extend
  import dmem_lsu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] outdata,
  input  logic [1:0]    size,
  input  logic          is_signed,
  output logic [DW-1:0] ext
);

  always_comb begin
    ext = outdata;
    case (size)
      SZ_BYTE: ext = {{(DW-8){is_signed & outdata[7]}}, outdata[7:0]};
      SZ_HALF: ext = {{(DW-16){is_signed & outdata[15]}}, outdata[15:0]};
      default: ext = outdata;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Single-outstanding load/store initiator for DMEM. Response 2 (error), 3 (store) or
// 3+RD_LAT (load) cycles after accept; req_ready only in IDLE, response held until resp_ready.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int AW     = 32,
  parameter int DW     = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err,
  output logic [AW-1:0] daddr,
  output logic [DW-1:0] indata,
  input  logic [DW-1:0] outdata,
  output logic [1:0]    str,
  output logic [1:0]    stw,
  output logic          we
);

  localparam logic [1:0] LAT = 2'(RD_LAT);

  state_t        state, state_nx;
  logic          l_we, l_signed;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
  logic [1:0]    l_size;
  logic [1:0]    cnt;
  logic          bad;
  logic [DW-1:0] ext_dat;

  assign bad = (l_size == SZ_BAD) ||
               (l_size == SZ_HALF && l_addr[0]) ||
               (l_size == SZ_WORD && l_addr[1:0] != 2'b00);

  assign req_ready = (state == IDLE);

  lsu_load_extend #(.DW(DW)) u_ext (
    .outdata   (outdata),
    .size      (l_size),
    .is_signed (l_signed),
    .ext       (ext_dat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // ISSUE counts as the first read-latency cycle, so RD_LAT=0 loads skip WAIT.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = ERR_CHK;
      ERR_CHK: state_nx = bad ? RESP : ISSUE;
      ISSUE:   state_nx = (l_we || cnt == 2'd0) ? RESP : WAIT;
      WAIT:    if (cnt == 2'd0) state_nx = RESP;
      RESP:    if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_we       <= 1'b0;
      l_signed   <= 1'b0;
      l_addr     <= '0;
      l_wdata    <= '0;
      l_size     <= SZ_BYTE;
      cnt        <= 2'd0;
      daddr      <= '0;
      indata     <= '0;
      str        <= 2'b00;
      stw        <= 2'b00;
      we         <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      we         <= (state == ERR_CHK) && !bad && l_we;
      resp_valid <= (state_nx == RESP);
      case (state)
        IDLE: if (req_valid) begin
          l_we     <= req_we;
          l_signed <= req_signed;
          l_addr   <= req_addr;
          l_wdata  <= req_wdata;
          l_size   <= req_size;
        end
        ERR_CHK: if (bad) begin
          resp_err   <= 1'b1;
          resp_rdata <= '0;
        end else begin
          daddr <= l_addr;
          cnt   <= LAT;
          if (l_we) begin
            stw    <= l_size;
            indata <= l_wdata;
          end else begin
            str <= l_size;
          end
        end
        ISSUE, WAIT: begin
          if (l_we) begin
            resp_err   <= 1'b0;
            resp_rdata <= '0;
          end else if (cnt == 2'd0) begin
            resp_err   <= 1'b0;
            resp_rdata <= ext_dat;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
